mealy_stream_ctrl: RTL and testbench

Sequencer that drives a serial Mealy sequence detector from a parallel test pattern. On `start` it latches a pattern and a bit count, pulses a clear to the detector, then shifts the pattern out one bit per clock LSB-first while sampling the detector's `z` output in the same cycle. It reports the number of detections and the bit index of the first one. It sits between a host/bench register interface and the `mealy` detector instance, replacing hand-written serial stimulus.

---
 rtl/mealy_stream_ctrl_pkg.sv | 26 ++
 rtl/mealy_stream_ctrl_if.sv | 37 +++
 rtl/mealy_hit_counter.sv | 49 ++++
 rtl/mealy_stream_ctrl.sv | 109 ++++++++++
 tb/tb_mealy_stream_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mealy_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mealy_ctrl_pkg
// Description : Shared widths, FSM state encodings and state type for the
//               Mealy detector stream sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mealy_ctrl_pkg;

  localparam int PAT_W = 16;
  localparam int CNT_W = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_CLEAR = S_CLEAR,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mealy_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mealy_stream_ctrl_if
// Description : Host/detector-side bundle of the stream sequencer. The master
//               side is the host plus the detector; the slave side is the
//               sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface mealy_stream_ctrl_if #(
  parameter int PAT_W = mealy_ctrl_pkg::PAT_W,
  parameter int CNT_W = mealy_ctrl_pkg::CNT_W
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] len;
  logic             det_clr;
  logic             det_in;
  logic             det_z;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] first_hit;
  logic             first_valid;

  modport master (
    output start, pattern, len, det_z,
    input  det_clr, det_in, busy, done, hit_cnt, first_hit, first_valid
  );

  modport slave (
    input  start, pattern, len, det_z,
    output det_clr, det_in, busy, done, hit_cnt, first_hit, first_valid
  );

endinterface
`default_nettype wire

// File: rtl/mealy_hit_counter.sv
`default_nettype none
// ============================================================================
// Module      : mealy_hit_counter
// Description : Counts detector hits and captures the index of the first hit.
//               Cleared when a run is accepted; values hold otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_hit_counter #(
  parameter int CNT_W = mealy_ctrl_pkg::CNT_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             en,
  input  wire logic [CNT_W-1:0] idx,
  output logic      [CNT_W-1:0] hit_cnt,
  output logic      [CNT_W-1:0] first_hit,
  output logic                  first_valid
);

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_first_hit;
  logic             r_first_valid;

  // Hit accumulation; the first enabled cycle also records its bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt     <= '0;
      r_first_hit   <= '0;
      r_first_valid <= 1'b0;
    end else if (clr) begin
      r_hit_cnt     <= '0;
      r_first_hit   <= '0;
      r_first_valid <= 1'b0;
    end else if (en) begin
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (!r_first_valid) begin
        r_first_hit   <= idx;
        r_first_valid <= 1'b1;
      end
    end
  end

  assign hit_cnt     = r_hit_cnt;
  assign first_hit   = r_first_hit;
  assign first_valid = r_first_valid;

endmodule
`default_nettype wire

// File: rtl/mealy_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mealy_stream_ctrl
// Description : Latches a parallel pattern, clears a serial Mealy detector,
//               shifts the pattern out LSB-first and tallies the detector's
//               z output (count and first-hit index).
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_stream_ctrl #(
  parameter int PAT_W = mealy_ctrl_pkg::PAT_W,
  parameter int CNT_W = mealy_ctrl_pkg::CNT_W
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mealy_stream_ctrl_if.slave bus
);

  import mealy_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] C_LEN_MAX = CNT_W'(PAT_W);

  state_e           r_state;
  state_e           w_next;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_idx;
  logic             r_det_clr;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic             w_shift;
  logic [CNT_W-1:0] w_len_clamp;

  assign w_accept    = (r_state == ST_IDLE) && bus.start;
  assign w_shift     = (r_state == ST_SHIFT);
  assign w_last      = (r_idx == r_len - CNT_W'(1));
  assign w_len_clamp = (bus.len > C_LEN_MAX) ? C_LEN_MAX : bus.len;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: a zero-length run skips SHIFT entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_CLEAR;
      ST_CLEAR: w_next = (r_len != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Pattern/length capture on an accepted start; index walks during SHIFT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat <= '0;
      r_len <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_pat <= bus.pattern;
      r_len <= w_len_clamp;
      r_idx <= '0;
    end else if (w_shift) begin
      r_idx <= r_idx + CNT_W'(1);
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_det_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_det_clr <= (w_next == ST_CLEAR);
      r_busy    <= (w_next == ST_CLEAR) || (w_next == ST_SHIFT);
      r_done    <= (w_next == ST_DONE);
    end
  end

  // Serial bit is a mask-and-reduce of the latched pattern so every bit is used.
  assign bus.det_in  = w_shift && (|(r_pat & (PAT_W'(1) << r_idx)));
  assign bus.det_clr = r_det_clr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  mealy_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (w_accept),
    .en          (w_shift && bus.det_z),
    .idx         (r_idx),
    .hit_cnt     (bus.hit_cnt),
    .first_hit   (bus.first_hit),
    .first_valid (bus.first_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_mealy_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_stream_ctrl
// Description : Self-checking bench for mealy_stream_ctrl: directed scenarios
//               plus randomized runs against a cycle-numbered reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_stream_ctrl;

  localparam int PAT_W = 16;
  localparam int CNT_W = 5;

  logic clk;
  logic rst;
  logic z_follow;
  logic z_drv;
  int   n_checks;
  int   n_errors;

  mealy_stream_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  // Detector stand-in: either echoes det_in or plays a bench-chosen value.
  assign bus.det_z = z_follow ? bus.det_in : z_drv;

  mealy_stream_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " det_clr"},     32'(bus.det_clr),     32'd0);
    chk({tag, " det_in"},      32'(bus.det_in),      32'd0);
    chk({tag, " busy"},        32'(bus.busy),        32'd0);
    chk({tag, " done"},        32'(bus.done),        32'd0);
    chk({tag, " hit_cnt"},     32'(bus.hit_cnt),     32'd0);
    chk({tag, " first_hit"},   32'(bus.first_hit),   32'd0);
    chk({tag, " first_valid"}, 32'(bus.first_valid), 32'd0);
  endtask

  // One run, numbered from the start edge (edge 0). Model: SHIFT cycle k sends
  // pat[k] and the tally counts z over the first min(c-2, L) shifted bits.
  //   zf       : det_z echoes det_in during SHIFT (else zm[k] is used)
  //   zout     : det_z value outside SHIFT
  //   extra_at : cycle in which a (to-be-ignored) start is pulsed, 0 = none
  //   abort_at : cycle in which reset is asserted, 0 = none
  task automatic run(input string name, input logic [15:0] pat, input logic [4:0] ln,
                     input bit zf, input logic [15:0] zm, input bit zout,
                     input int extra_at, input int abort_at);
    int          L;
    logic [15:0] zb;
    int          nsh;
    int          exp_hits;
    int          exp_first;
    bit          exp_valid;
    bit          in_shift;
    int          k;
    L  = (int'(ln) > PAT_W) ? PAT_W : int'(ln);
    zb = zf ? pat : zm;
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = ln;
    z_follow    = 1'b0;
    z_drv       = zout;
    @(posedge clk);
    for (int c = 1; c <= L + 3; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        chk_all_zero($sformatf("%s abort c%0d", name, c));
        bus.start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("%s in-reset done", name), 32'(bus.done), 32'd0);
          chk($sformatf("%s in-reset busy", name), 32'(bus.busy), 32'd0);
        end
        rst = 1'b1;
        return;
      end
      if (c == extra_at) begin
        bus.start   = 1'b1;
        bus.pattern = 16'hFFFF;
        bus.len     = 5'd4;
      end else begin
        bus.start   = 1'b0;
        bus.pattern = 16'($urandom);
        bus.len     = 5'($urandom);
      end
      in_shift = (c >= 2) && (c <= L + 1);
      k        = in_shift ? c - 2 : 0;
      z_follow = in_shift && zf;
      z_drv    = in_shift ? zm[k] : zout;
      nsh       = (c - 2 < 0) ? 0 : ((c - 2 > L) ? L : c - 2);
      exp_hits  = 0;
      exp_first = 0;
      exp_valid = 1'b0;
      for (int j = 0; j < nsh; j++) begin
        if (zb[j]) begin
          if (!exp_valid) exp_first = j;
          exp_valid = 1'b1;
          exp_hits++;
        end
      end
      #1;
      chk($sformatf("%s c%0d det_in", name, c),  32'(bus.det_in),  32'(in_shift ? pat[k] : 1'b0));
      chk($sformatf("%s c%0d det_clr", name, c), 32'(bus.det_clr), 32'(c == 1));
      chk($sformatf("%s c%0d busy", name, c),    32'(bus.busy),    32'(c >= 1 && c <= L + 1));
      chk($sformatf("%s c%0d done", name, c),    32'(bus.done),    32'(c == L + 2));
      chk($sformatf("%s c%0d hit_cnt", name, c),     32'(bus.hit_cnt),     32'(exp_hits));
      chk($sformatf("%s c%0d first_valid", name, c), 32'(bus.first_valid), 32'(exp_valid));
      chk($sformatf("%s c%0d first_hit", name, c),   32'(bus.first_hit),   32'(exp_first));
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int ln;
    int ea;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    z_follow    = 1'b0;
    z_drv       = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run("s1_00F5",   16'h00F5, 5'd8,  1'b1, 16'h0000, 1'b0, 0, 0);
    run("s2_len0",   16'hFFFF, 5'd0,  1'b1, 16'h0000, 1'b0, 0, 0);
    run("s3_clamp",  16'h8000, 5'd20, 1'b1, 16'h0000, 1'b0, 0, 0);
    run("s4_ignore", 16'h0003, 5'd4,  1'b1, 16'h0000, 1'b0, 3, 0);
    run("s5_abort",  16'h00A5, 5'd8,  1'b1, 16'h0000, 1'b0, 0, 5);
    run("s5_fresh",  16'h0001, 5'd1,  1'b1, 16'h0000, 1'b0, 0, 0);
    run("s6_zout",   16'h00FF, 5'd8,  1'b0, 16'h0000, 1'b1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      ln = $urandom_range(0, 20);
      ea = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ((ln > PAT_W) ? PAT_W : ln) + 2) : 0;
      run($sformatf("rnd%0d", i), 16'($urandom), 5'(ln), 1'($urandom), 16'($urandom),
          1'($urandom), ea, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
